// File: rtl/sram_cluster_pkg.sv
// Shared types for the four-macro SRAM cluster: width modes,
// unit select codes, request entries and the width priority decode.
package sram_cluster_pkg;

    typedef enum logic [2:0] {
        MODE_1,
        MODE_2,
        MODE_4,
        MODE_8,
        MODE_16,
        MODE_32
    } mode_t;

    localparam logic [1:0] UNIT_A = 2'b00;
    localparam logic [1:0] UNIT_B = 2'b01;
    localparam logic [1:0] UNIT_C = 2'b10;
    localparam logic [1:0] UNIT_D = 2'b11;

    typedef struct packed {
        mode_t      mode;
        logic [1:0] sel;
        logic [2:0] sub_sel;
    } req_t;

    // Widest set bit wins; no bit set falls back to byte mode.
    function automatic mode_t decode_mode(
        input logic c32,
        input logic c16,
        input logic c8,
        input logic c4,
        input logic c2,
        input logic c1
    );
        mode_t m;
        priority case (1'b1)
            c32:     m = MODE_32;
            c16:     m = MODE_16;
            c8:      m = MODE_8;
            c4:      m = MODE_4;
            c2:      m = MODE_2;
            c1:      m = MODE_1;
            default: m = MODE_8;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_cluster_read_collector_if.sv
// Read-request / read-return bundle between the cluster control
// side (master) and the read collector (slave).
interface sram_cluster_read_collector_if;

    logic        rd_req;
    logic [1:0]  unit_2_4_dec_sel;
    logic        c32;
    logic        c16;
    logic        c8;
    logic        c4;
    logic        c2;
    logic        c1;
    logic [2:0]  sub_sel;
    logic [7:0]  dout_A;
    logic [7:0]  dout_B;
    logic [7:0]  dout_C;
    logic [7:0]  dout_D;
    logic [31:0] d_fabric_out;
    logic        rd_valid;

    modport master (
        output rd_req, unit_2_4_dec_sel,
        output c32, c16, c8, c4, c2, c1,
        output sub_sel,
        output dout_A, dout_B, dout_C, dout_D,
        input  d_fabric_out, rd_valid
    );

    modport slave (
        input  rd_req, unit_2_4_dec_sel,
        input  c32, c16, c8, c4, c2, c1,
        input  sub_sel,
        input  dout_A, dout_B, dout_C, dout_D,
        output d_fabric_out, rd_valid
    );

endinterface

// File: rtl/sram_subword_extract.sv
// Picks a zero-extended 8/4/2/1-bit field out of one macro byte
// according to the captured width mode and sub-byte position.
module sram_subword_extract
    import sram_cluster_pkg::*;
(
    input  logic [7:0] byte_in,
    input  mode_t      mode,
    input  logic [2:0] sub_sel,
    output logic [7:0] sub_word
);

    always_comb begin
        sub_word = '0;
        case (mode)
            MODE_4: begin
                sub_word[3:0] = sub_sel[0] ? byte_in[7:4]
                                           : byte_in[3:0];
            end
            MODE_2: begin
                sub_word[1:0] = byte_in[{sub_sel[1:0], 1'b0} +: 2];
            end
            MODE_1: begin
                sub_word[0] = byte_in[sub_sel];
            end
            default: begin
                sub_word = byte_in;
            end
        endcase
    end

endmodule

// File: rtl/sram_cluster_read_collector.sv
// Read-return stage of the SRAM cluster: captures request config,
// waits RD_LAT cycles, aligns macro bytes. Option: SRAM_RDATA_HOLD_EN.
module sram_cluster_read_collector
    import sram_cluster_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input logic                          clk,
    input logic                          rst_n,
    sram_cluster_read_collector_if.slave bus
);

    req_t               new_req;
    req_t [RD_LAT:1]    ent;
    logic [RD_LAT:1]    vld;
    req_t               cap;
    logic [7:0]         sel_byte;
    logic [7:0]         sub_word;
    logic [31:0]        word;
    logic [31:0]        d_q;
    logic               v_q;

    always_comb begin
        new_req.mode    = decode_mode(bus.c32, bus.c16, bus.c8,
                                      bus.c4, bus.c2, bus.c1);
        new_req.sel     = bus.unit_2_4_dec_sel;
        new_req.sub_sel = bus.sub_sel;
    end

    // Entries only move forward; later config changes never reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            ent <= '0;
        end else begin
            vld[1] <= bus.rd_req;
            ent[1] <= new_req;
            for (int i = 2; i <= RD_LAT; i++) begin
                vld[i] <= vld[i-1];
                ent[i] <= ent[i-1];
            end
        end
    end

    assign cap = ent[RD_LAT];

    always_comb begin
        sel_byte = bus.dout_A;
        case (cap.sel)
            UNIT_A:  sel_byte = bus.dout_A;
            UNIT_B:  sel_byte = bus.dout_B;
            UNIT_C:  sel_byte = bus.dout_C;
            UNIT_D:  sel_byte = bus.dout_D;
            default: sel_byte = bus.dout_A;
        endcase
    end

    sram_subword_extract u_extract (
        .byte_in  (sel_byte),
        .mode     (cap.mode),
        .sub_sel  (cap.sub_sel),
        .sub_word (sub_word)
    );

    always_comb begin
        word = '0;
        case (cap.mode)
            MODE_32: begin
                word = {bus.dout_A, bus.dout_B,
                        bus.dout_C, bus.dout_D};
            end
            MODE_16: begin
                word[15:0] = cap.sel[0]
                           ? {bus.dout_C, bus.dout_D}
                           : {bus.dout_A, bus.dout_B};
            end
            default: begin
                word[7:0] = sub_word;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
            v_q <= 1'b0;
        end else begin
            v_q <= vld[RD_LAT];
`ifdef SRAM_RDATA_HOLD_EN
            if (vld[RD_LAT]) begin
                d_q <= word;
            end
`else
            // Idle output is zero so the fabric can OR-combine returns.
            d_q <= vld[RD_LAT] ? word : '0;
`endif
        end
    end

    assign bus.d_fabric_out = d_q;
    assign bus.rd_valid     = v_q;

endmodule

// File: tb/tb_sram_cluster_read_collector.sv
// Directed self-checking bench for sram_cluster_read_collector
// (RD_LAT=1); idle-output expectation follows SRAM_RDATA_HOLD_EN.
module tb_sram_cluster_read_collector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] last_word = '0;

`ifdef SRAM_RDATA_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    always #5 clk = ~clk;

    sram_cluster_read_collector_if bus ();

    sram_cluster_read_collector #(.RD_LAT(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] idle_exp();
        return HOLD ? last_word : 32'h0;
    endfunction

    task automatic idle_in();
        bus.rd_req = 1'b0;
        bus.unit_2_4_dec_sel = 2'b00;
        {bus.c32, bus.c16, bus.c8, bus.c4, bus.c2, bus.c1} = 6'b0;
        bus.sub_sel = 3'b000;
    endtask

    task automatic set_dout(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] c, input logic [7:0] d);
        bus.dout_A = a;
        bus.dout_B = b;
        bus.dout_C = c;
        bus.dout_D = d;
    endtask

    // c = {c32,c16,c8,c4,c2,c1}
    task automatic drive_req(input logic [5:0] c, input logic [1:0] sel,
                             input logic [2:0] sub);
        bus.rd_req = 1'b1;
        {bus.c32, bus.c16, bus.c8, bus.c4, bus.c2, bus.c1} = c;
        bus.unit_2_4_dec_sel = sel;
        bus.sub_sel = sub;
    endtask

    task automatic test_reset();
        idle_in();
        set_dout(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_hold: valid=%b d=%h want 0/0",
                         bus.rd_valid, bus.d_fabric_out);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_release: valid=%b d=%h want 0/0",
                         bus.rd_valid, bus.d_fabric_out);
            end
        end
    endtask

    task automatic test_read32();
        @(negedge clk);
        drive_req(6'b100000, 2'b10, 3'b000);
        set_dout(8'hEE, 8'hEE, 8'hEE, 8'hEE);
        @(negedge clk);
        idle_in();
        set_dout(8'h11, 8'h22, 8'h33, 8'h44);
        n_checks++;
        if (bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL r32_early: valid=%b want 0", bus.rd_valid);
        end
        @(negedge clk);
        set_dout(8'h99, 8'h99, 8'h99, 8'h99);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h11223344) begin
            n_fail++;
            $display("FAIL r32: valid=%b d=%h want 1/11223344",
                     bus.rd_valid, bus.d_fabric_out);
        end
        last_word = 32'h11223344;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== idle_exp()) begin
            n_fail++;
            $display("FAIL r32_after: valid=%b d=%h want 0/%h",
                     bus.rd_valid, bus.d_fabric_out, idle_exp());
        end
    endtask

    task automatic test_read16_8();
        @(negedge clk);
        drive_req(6'b010000, 2'b01, 3'b000);
        set_dout(8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        drive_req(6'b001000, 2'b10, 3'b000);
        set_dout(8'h12, 8'h34, 8'hAB, 8'hCD);
        @(negedge clk);
        idle_in();
        set_dout(8'h77, 8'h66, 8'h5A, 8'h55);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000ABCD) begin
            n_fail++;
            $display("FAIL r16: valid=%b d=%h want 1/0000abcd",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        set_dout(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000005A) begin
            n_fail++;
            $display("FAIL r8: valid=%b d=%h want 1/0000005a",
                     bus.rd_valid, bus.d_fabric_out);
        end
        last_word = 32'h0000005A;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== idle_exp()) begin
            n_fail++;
            $display("FAIL r8_after: valid=%b d=%h want 0/%h",
                     bus.rd_valid, bus.d_fabric_out, idle_exp());
        end
    endtask

    task automatic test_subbyte();
        // c2 pair 2 of 8'b00_11_01_10 -> 3
        @(negedge clk);
        drive_req(6'b000010, 2'b11, 3'b010);
        @(negedge clk);
        // c1 bit 7 of 8'h80 -> 1 (bit 7 of 8'h36 is 0)
        drive_req(6'b000001, 2'b11, 3'd7);
        set_dout(8'hFF, 8'hFF, 8'hFF, 8'b00_11_01_10);
        @(negedge clk);
        // c4 high nibble of 8'hB7 -> B
        drive_req(6'b000100, 2'b00, 3'b001);
        set_dout(8'h7F, 8'h7F, 8'h7F, 8'h80);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h00000003) begin
            n_fail++;
            $display("FAIL r2: valid=%b d=%h want 1/00000003",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        // c16 beats c4: sel[0]=0 -> {A,B}
        drive_req(6'b010100, 2'b10, 3'b000);
        set_dout(8'hB7, 8'h00, 8'h00, 8'h00);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h00000001) begin
            n_fail++;
            $display("FAIL r1: valid=%b d=%h want 1/00000001",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        // no c-bit set -> byte mode, unit B
        drive_req(6'b000000, 2'b01, 3'b111);
        set_dout(8'hC3, 8'h3C, 8'h11, 8'h22);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000000B) begin
            n_fail++;
            $display("FAIL r4: valid=%b d=%h want 1/0000000b",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        idle_in();
        set_dout(8'h01, 8'hE4, 8'h02, 8'h03);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000C33C) begin
            n_fail++;
            $display("FAIL prio16: valid=%b d=%h want 1/0000c33c",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        set_dout(8'h00, 8'h00, 8'h00, 8'h00);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h000000E4) begin
            n_fail++;
            $display("FAIL default8: valid=%b d=%h want 1/000000e4",
                     bus.rd_valid, bus.d_fabric_out);
        end
        last_word = 32'h000000E4;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== idle_exp()) begin
            n_fail++;
            $display("FAIL sub_after: valid=%b d=%h want 0/%h",
                     bus.rd_valid, bus.d_fabric_out, idle_exp());
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive_req(6'b100000, 2'b11, 3'b000);
        @(negedge clk);
        drive_req(6'b001000, 2'b00, 3'b000);
        set_dout(8'h12, 8'h34, 8'h56, 8'h78);
        n_checks++;
        if (bus.rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_early: valid=%b want 0", bus.rd_valid);
        end
        @(negedge clk);
        idle_in();
        set_dout(8'h9C, 8'hF0, 8'hF0, 8'hF0);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h12345678) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b d=%h want 1/12345678",
                     bus.rd_valid, bus.d_fabric_out);
        end
        @(negedge clk);
        set_dout(8'hAA, 8'hAA, 8'hAA, 8'hAA);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000009C) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b d=%h want 1/0000009c",
                     bus.rd_valid, bus.d_fabric_out);
        end
        last_word = 32'h0000009C;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== idle_exp()) begin
            n_fail++;
            $display("FAIL b2b_after: valid=%b d=%h want 0/%h",
                     bus.rd_valid, bus.d_fabric_out, idle_exp());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive_req(6'b100000, 2'b00, 3'b000);
        @(negedge clk);
        idle_in();
        set_dout(8'hDE, 8'hAD, 8'hBE, 8'hEF);
        rst_n = 1'b0;
        last_word = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_rst_in: valid=%b d=%h want 0/0",
                     bus.rd_valid, bus.d_fabric_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_rst_post: valid=%b d=%h want 0/0",
                         bus.rd_valid, bus.d_fabric_out);
            end
        end
        @(negedge clk);
        drive_req(6'b001000, 2'b00, 3'b000);
        @(negedge clk);
        idle_in();
        set_dout(8'h3C, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b1 || bus.d_fabric_out !== 32'h0000003C) begin
            n_fail++;
            $display("FAIL cold_read: valid=%b d=%h want 1/0000003c",
                     bus.rd_valid, bus.d_fabric_out);
        end
        last_word = 32'h0000003C;
        @(negedge clk);
        n_checks++;
        if (bus.rd_valid !== 1'b0 || bus.d_fabric_out !== idle_exp()) begin
            n_fail++;
            $display("FAIL cold_after: valid=%b d=%h want 0/%h",
                     bus.rd_valid, bus.d_fabric_out, idle_exp());
        end
    endtask

    initial begin
        idle_in();
        set_dout(8'h00, 8'h00, 8'h00, 8'h00);
        test_reset();
        test_read32();
        test_read16_8();
        test_subbyte();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
